// File: rtl/pipe_pkg.sv
// Shared pipeline types: load kinds and writeback source selection.
package pipe_pkg;

    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_LB   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LH   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LW   = 3'd5,
        LT_LWU  = 3'd6,
        LT_LD   = 3'd7
    } load_type_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_HI   = 2'd2,
        WB_LO   = 2'd3
    } wbsel_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bus: M-stage instruction fields in, committed W-stage results out.
interface wb_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) ();

    logic                  stallW;
    logic                  flushW;
    logic                  validM;
    logic [XLEN-1:0]       aluoutM;
    logic [XLEN-1:0]       memdataM;
    pipe_pkg::load_type_e  load_typeM;
    pipe_pkg::wbsel_e      wbselM;
    logic                  regwriteM;
    logic [REG_AW-1:0]     writeregM;
    logic [1:0]            hilo_weM;
    logic [XLEN-1:0]       hi_wdataM;
    logic [XLEN-1:0]       lo_wdataM;

    logic                  reg_weW;
    logic [REG_AW-1:0]     reg_waddrW;
    logic [XLEN-1:0]       reg_wdataW;
    logic [XLEN-1:0]       hiW;
    logic [XLEN-1:0]       loW;
    logic                  misalignW;
    logic [CNT_W-1:0]      instretW;

    // The pipeline side that issues instructions into the stage
    modport master (
        output stallW, flushW, validM, aluoutM, memdataM, load_typeM, wbselM,
               regwriteM, writeregM, hilo_weM, hi_wdataM, lo_wdataM,
        input  reg_weW, reg_waddrW, reg_wdataW, hiW, loW, misalignW, instretW
    );

    // The writeback stage itself
    modport slave (
        input  stallW, flushW, validM, aluoutM, memdataM, load_typeM, wbselM,
               regwriteM, writeregM, hilo_weM, hi_wdataM, lo_wdataM,
        output reg_weW, reg_waddrW, reg_wdataW, hiW, loW, misalignW, instretW
    );

endinterface

// File: rtl/load_align.sv
// Combinational load-data lane select, sign/zero extension and alignment check.
module load_align
    import pipe_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  memdata,
    input  logic [OFF_W-1:0] offset,
    input  load_type_e       load_type,
    output logic [XLEN-1:0]  data,
    output logic             misalign
);

    logic [XLEN-1:0] shifted;

    // Move the addressed byte lane down to bit 0, then extend by load kind;
    // on a 32-bit datapath LWU and LD collapse onto the plain word load.
    always_comb begin
        shifted  = memdata >> {offset, 3'b000};
        data     = '0;
        misalign = 1'b0;
        case (load_type)
            LT_LB:  data = XLEN'($signed(shifted[7:0]));
            LT_LBU: data = XLEN'(shifted[7:0]);
            LT_LH: begin
                data     = XLEN'($signed(shifted[15:0]));
                misalign = offset[0];
            end
            LT_LHU: begin
                data     = XLEN'(shifted[15:0]);
                misalign = offset[0];
            end
            LT_LW: begin
                data     = XLEN'($signed(shifted[31:0]));
                misalign = |offset[1:0];
            end
            LT_LWU: begin
                data     = XLEN'(shifted[31:0]);
                misalign = |offset[1:0];
            end
            LT_LD: begin
                data     = shifted;
                misalign = |offset;
            end
            default: begin
                data     = '0;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered MEM/WB stage: W pipeline register, HI/LO, retire counter and
// the final register-file write mux. XLEN must be 32 or 64.
module wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_stage_if.slave bus
);

    localparam int OFF_W = $clog2(XLEN/8);

    logic              validW;
    logic [XLEN-1:0]   aluoutW;
    logic [XLEN-1:0]   memdataW;
    load_type_e        load_typeW;
    wbsel_e            wbselW;
    logic              regwriteW;
    logic [REG_AW-1:0] writeregW;
    logic [1:0]        hilo_weW;
    logic [XLEN-1:0]   hi_wdataW;
    logic [XLEN-1:0]   lo_wdataW;

    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [CNT_W-1:0]  instret_q;

    logic [XLEN-1:0]   load_data;
    logic              load_mis;
    logic              misaligned;
    logic              commit;
    logic [XLEN-1:0]   wdata;

    assign commit     = validW & ~bus.stallW;
    assign misaligned = validW & load_mis;

    // W pipeline register: hold on stall, bubble on flush, otherwise capture M
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validW     <= 1'b0;
            aluoutW    <= '0;
            memdataW   <= '0;
            load_typeW <= LT_NONE;
            wbselW     <= WB_ALU;
            regwriteW  <= 1'b0;
            writeregW  <= '0;
            hilo_weW   <= '0;
            hi_wdataW  <= '0;
            lo_wdataW  <= '0;
        end else if (!bus.stallW) begin
            if (bus.flushW) begin
                validW <= 1'b0;
            end else begin
                validW     <= bus.validM;
                aluoutW    <= bus.aluoutM;
                memdataW   <= bus.memdataM;
                load_typeW <= bus.load_typeM;
                wbselW     <= bus.wbselM;
                regwriteW  <= bus.regwriteM;
                writeregW  <= bus.writeregM;
                hilo_weW   <= bus.hilo_weM;
                hi_wdataW  <= bus.hi_wdataM;
                lo_wdataW  <= bus.lo_wdataM;
            end
        end
    end

    // Architectural HI/LO and retire count change only when W commits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            instret_q <= '0;
        end else if (commit) begin
            if (hilo_weW[1]) begin
                hi_q <= hi_wdataW;
            end
            if (hilo_weW[0]) begin
                lo_q <= lo_wdataW;
            end
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .memdata  (memdataW),
        .offset   (aluoutW[OFF_W-1:0]),
        .load_type(load_typeW),
        .data     (load_data),
        .misalign (load_mis)
    );

    // Writeback source select; HI/LO reads see the pre-commit value
    always_comb begin
        wdata = aluoutW;
        case (wbselW)
            WB_ALU:  wdata = aluoutW;
            WB_LOAD: wdata = load_data;
            WB_HI:   wdata = hi_q;
            WB_LO:   wdata = lo_q;
            default: wdata = aluoutW;
        endcase
    end

    assign bus.reg_weW    = validW & regwriteW & (writeregW != '0) & ~misaligned;
    assign bus.reg_waddrW = writeregW;
    assign bus.reg_wdataW = wdata;
    assign bus.hiW        = hi_q;
    assign bus.loW        = lo_q;
    assign bus.misalignW  = misaligned;
    assign bus.instretW   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a 32-bit instance and a 64-bit instance
// with a 4-bit retire counter, both driven by the same instruction stream.
module tb_wb_stage;
    import pipe_pkg::*;

    typedef struct {
        bit              valid;
        longint unsigned alu;
        longint unsigned mem;
        int              lt;
        int              ws;
        bit              rw;
        int              wr;
        int              hwe;
        longint unsigned hd;
        longint unsigned ld;
    } instr_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instr_t          mW[2];
    longint unsigned mHi[2];
    longint unsigned mLo[2];
    longint unsigned mCnt[2];

    wb_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) if32 ();
    wb_stage_if #(.XLEN(64), .REG_AW(5), .CNT_W(4))  if64 ();

    wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(32)) dut32 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if32)
    );

    wb_stage #(.XLEN(64), .REG_AW(5), .CNT_W(4)) dut64 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if64)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int xlenOf(int k);
        return (k == 0) ? 32 : 64;
    endfunction

    function automatic longint unsigned xmask(int k);
        return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic longint unsigned cmask(int k);
        return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hF;
    endfunction

    // Access size in bytes; a doubleword on a 32-bit datapath is a word
    function automatic int loadBytes(int lt, int xl);
        case (lt)
            1, 2:    return 1;
            3, 4:    return 2;
            5, 6:    return 4;
            7:       return xl / 8;
            default: return 0;
        endcase
    endfunction

    function automatic bit loadSigned(int lt);
        return (lt == 1) || (lt == 3) || (lt == 5) || (lt == 7);
    endfunction

    function automatic bit isMisaligned(int k, instr_t w);
        int n;
        int off;
        n   = loadBytes(w.lt, xlenOf(k));
        off = int'(w.alu % longint'(xlenOf(k) / 8));
        return (n > 1) && ((off % n) != 0);
    endfunction

    function automatic longint unsigned loadValue(int k, instr_t w);
        int              n;
        int              off;
        longint unsigned v;
        n   = loadBytes(w.lt, xlenOf(k));
        off = int'(w.alu % longint'(xlenOf(k) / 8));
        if (n == 0) return 0;
        v = (w.mem & xmask(k)) >> (8 * off);
        if (n < 8) begin
            v = v % (64'd1 << (8 * n));
            if (loadSigned(w.lt) && (v >= (64'd1 << (8 * n - 1))))
                v = v - (64'd1 << (8 * n));
        end
        return v & xmask(k);
    endfunction

    function automatic instr_t mk(bit valid, longint unsigned alu, longint unsigned mem,
                                  int lt, int ws, bit rw, int wr, int hwe,
                                  longint unsigned hd, longint unsigned ld);
        instr_t d;
        d.valid = valid; d.alu = alu; d.mem = mem; d.lt = lt; d.ws = ws;
        d.rw = rw; d.wr = wr; d.hwe = hwe; d.hd = hd; d.ld = ld;
        return d;
    endfunction

    function automatic instr_t genInstr();
        instr_t d;
        d.valid = ($urandom_range(0, 9) < 8);
        d.alu   = {$urandom, $urandom};
        d.mem   = {$urandom, $urandom};
        d.lt    = int'($urandom_range(0, 7));
        d.ws    = int'($urandom_range(0, 3));
        d.rw    = 1'($urandom_range(0, 1));
        d.wr    = int'($urandom_range(0, 31));
        d.hwe   = int'($urandom_range(0, 3));
        d.hd    = {$urandom, $urandom};
        d.ld    = {$urandom, $urandom};
        return d;
    endfunction

    // Count one comparison and report it if the values differ
    task automatic checkOutput(string tag, longint unsigned got, longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one clock edge for both instances
    task automatic modelEdge(bit stall, bit flush, instr_t d);
        for (int k = 0; k < 2; k++) begin
            if (!stall) begin
                if (mW[k].valid) begin
                    if (mW[k].hwe[1]) mHi[k] = mW[k].hd & xmask(k);
                    if (mW[k].hwe[0]) mLo[k] = mW[k].ld & xmask(k);
                    mCnt[k] = (mCnt[k] + 1) & cmask(k);
                end
                if (flush) mW[k].valid = 1'b0;
                else       mW[k] = d;
            end
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mW[k]   = mk(1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
            mHi[k]  = 0;
            mLo[k]  = 0;
            mCnt[k] = 0;
        end
    endtask

    // Compare every observable output of instance k against the model
    task automatic checkDut(int k);
        bit              we;
        bit              mis;
        longint unsigned waddr;
        longint unsigned wdata;
        longint unsigned hi;
        longint unsigned lo;
        longint unsigned cnt;
        longint unsigned expData;
        bit              expMis;
        bit              expWe;
        instr_t          w;
        string           p;
        if (k == 0) begin
            we = if32.reg_weW; mis = if32.misalignW; waddr = 64'(if32.reg_waddrW);
            wdata = 64'(if32.reg_wdataW); hi = 64'(if32.hiW); lo = 64'(if32.loW);
            cnt = 64'(if32.instretW);
        end else begin
            we = if64.reg_weW; mis = if64.misalignW; waddr = 64'(if64.reg_waddrW);
            wdata = 64'(if64.reg_wdataW); hi = 64'(if64.hiW); lo = 64'(if64.loW);
            cnt = 64'(if64.instretW);
        end
        w      = mW[k];
        p      = $sformatf("x%0d", xlenOf(k));
        expMis = w.valid && isMisaligned(k, w);
        expWe  = w.valid && w.rw && (w.wr % 32 != 0) && !expMis;
        case (w.ws)
            0:       expData = w.alu & xmask(k);
            1:       expData = loadValue(k, w);
            2:       expData = mHi[k];
            default: expData = mLo[k];
        endcase
        checkOutput({p, " reg_weW"}, 64'(we), 64'(expWe));
        checkOutput({p, " misalignW"}, 64'(mis), 64'(expMis));
        checkOutput({p, " hiW"}, hi, mHi[k]);
        checkOutput({p, " loW"}, lo, mLo[k]);
        checkOutput({p, " instretW"}, cnt, mCnt[k]);
        if (w.valid) begin
            checkOutput({p, " reg_waddrW"}, waddr, longint'(w.wr % 32));
            checkOutput({p, " reg_wdataW"}, wdata, expData);
        end
    endtask

    // Drive one cycle of M-stage inputs, clock it, then check both instances
    task automatic applyStimulus(bit stall, bit flush, instr_t d);
        if32.stallW = stall;            if64.stallW = stall;
        if32.flushW = flush;            if64.flushW = flush;
        if32.validM = d.valid;          if64.validM = d.valid;
        if32.aluoutM = d.alu[31:0];     if64.aluoutM = d.alu;
        if32.memdataM = d.mem[31:0];    if64.memdataM = d.mem;
        if32.load_typeM = load_type_e'(d.lt[2:0]);
        if64.load_typeM = load_type_e'(d.lt[2:0]);
        if32.wbselM = wbsel_e'(d.ws[1:0]);
        if64.wbselM = wbsel_e'(d.ws[1:0]);
        if32.regwriteM = d.rw;          if64.regwriteM = d.rw;
        if32.writeregM = d.wr[4:0];     if64.writeregM = d.wr[4:0];
        if32.hilo_weM = d.hwe[1:0];     if64.hilo_weM = d.hwe[1:0];
        if32.hi_wdataM = d.hd[31:0];    if64.hi_wdataM = d.hd;
        if32.lo_wdataM = d.ld[31:0];    if64.lo_wdataM = d.ld;
        @(posedge clk);
        if (rst_n) modelEdge(stall, flush, d);
        #1;
        checkDut(0);
        checkDut(1);
        @(negedge clk);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock
    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst reg_weW", 64'(if32.reg_weW), 0);
        checkOutput("rst reg_wdataW", 64'(if32.reg_wdataW), 0);
        checkOutput("rst misalignW", 64'(if32.misalignW), 0);
        checkOutput("rst x64 reg_wdataW", 64'(if64.reg_wdataW), 0);
        checkDut(0);
        checkDut(1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    instr_t idle;
    instr_t d;
    int              lt32[5];
    int              off32[5];
    longint unsigned exp32[5];
    int              lt64[3];
    int              off64[3];
    longint unsigned exp64[3];

    initial begin
        checks = 0;
        errors = 0;
        idle   = mk(1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
        lt32  = '{1, 2, 3, 4, 5};
        off32 = '{0, 2, 2, 0, 0};
        exp32 = '{64'hFFFFFFBB, 64'h99, 64'hFFFF8899, 64'hAABB, 64'h8899AABB};
        lt64  = '{7, 6, 5};
        off64 = '{0, 4, 4};
        exp64 = '{64'hF0E1D2C38899AABB, 64'h00000000F0E1D2C3, 64'hFFFFFFFFF0E1D2C3};

        // Power-up reset
        rst_n = 1'b0;
        if32.stallW = 1'b0; if64.stallW = 1'b0;
        if32.flushW = 1'b0; if64.flushW = 1'b0;
        if32.validM = 1'b0; if64.validM = 1'b0;
        modelReset();
        @(negedge clk);
        checkDut(0);
        checkDut(1);
        rst_n = 1'b1;

        // First ALU op after reset writes one cycle later
        applyStimulus(1'b0, 1'b0, mk(1'b1, 64'h1234, 0, 0, 0, 1'b1, 5, 0, 0, 0));
        checkOutput("first alu we", 64'(if32.reg_weW), 1);
        checkOutput("first alu data", 64'(if32.reg_wdataW), 64'h1234);

        // Load extraction examples
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, mk(1'b1, longint'(off32[i]), 64'hF0E1D2C3_8899AABB,
                                         lt32[i], 1, 1'b1, 7, 0, 0, 0));
            checkOutput($sformatf("load32 lt%0d off%0d", lt32[i], off32[i]),
                        64'(if32.reg_wdataW), exp32[i]);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, mk(1'b1, longint'(off64[i]), 64'hF0E1D2C3_8899AABB,
                                         lt64[i], 1, 1'b1, 8, 0, 0, 0));
            checkOutput($sformatf("load64 lt%0d off%0d", lt64[i], off64[i]),
                        64'(if64.reg_wdataW), exp64[i]);
        end

        // Misaligned halfword and word loads
        applyStimulus(1'b0, 1'b0, mk(1'b1, 1, 64'h8899AABB, 3, 1, 1'b1, 9, 0, 0, 0));
        checkOutput("mis lh misalignW", 64'(if32.misalignW), 1);
        checkOutput("mis lh reg_weW", 64'(if32.reg_weW), 0);
        applyStimulus(1'b0, 1'b0, mk(1'b1, 2, 64'h8899AABB, 5, 1, 1'b1, 9, 0, 0, 0));
        checkOutput("mis lw misalignW", 64'(if32.misalignW), 1);
        checkOutput("mis lw reg_weW", 64'(if32.reg_weW), 0);

        // HI/LO write followed by mfhi and mflo
        applyStimulus(1'b0, 1'b0, mk(1'b1, 0, 0, 0, 0, 1'b0, 0, 3, 64'h1, 64'h2));
        applyStimulus(1'b0, 1'b0, mk(1'b1, 0, 0, 0, 2, 1'b1, 4, 0, 0, 0));
        checkOutput("mfhi data", 64'(if32.reg_wdataW), 64'h1);
        applyStimulus(1'b0, 1'b0, mk(1'b1, 0, 0, 0, 3, 1'b1, 4, 0, 0, 0));
        checkOutput("mflo data", 64'(if32.reg_wdataW), 64'h2);

        // Stall for three cycles, then flush, then flush while stalled
        applyStimulus(1'b0, 1'b0, mk(1'b1, 64'hAAAA, 0, 0, 0, 1'b1, 9, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, mk(1'b1, 64'h5555, 0, 0, 0, 1'b1, 10, 3, 64'h77, 64'h66));
            checkOutput("stall data", 64'(if32.reg_wdataW), 64'hAAAA);
        end
        applyStimulus(1'b0, 1'b1, mk(1'b1, 64'h5555, 0, 0, 0, 1'b1, 10, 3, 64'h77, 64'h66));
        checkOutput("flush reg_weW", 64'(if32.reg_weW), 0);
        applyStimulus(1'b0, 1'b0, idle);
        checkOutput("flush hiW", 64'(if32.hiW), 64'h1);
        applyStimulus(1'b0, 1'b0, mk(1'b1, 64'hBEEF, 0, 0, 0, 1'b1, 11, 0, 0, 0));
        applyStimulus(1'b1, 1'b1, idle);
        checkOutput("stalled flush we", 64'(if32.reg_weW), 1);

        // Register $0 is never written
        applyStimulus(1'b0, 1'b0, mk(1'b1, 64'h42, 0, 0, 0, 1'b1, 0, 0, 0, 0));
        checkOutput("r0 reg_weW", 64'(if32.reg_weW), 0);

        // Reset mid-stream, then the first op writes one cycle later
        applyStimulus(1'b0, 1'b0, mk(1'b1, 64'h99, 0, 0, 0, 1'b1, 12, 3, 64'h5, 64'h6));
        doReset();
        applyStimulus(1'b0, 1'b0, mk(1'b1, 64'h77, 0, 0, 0, 1'b1, 13, 0, 0, 0));
        checkOutput("post rst we", 64'(if32.reg_weW), 1);

        // Counter wrap on the 4-bit instance after 16 commits
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, 1'b0, mk(1'b1, longint'(i), 0, 0, 0, 1'b1, 1, 0, 0, 0));
        end
        checkOutput("wrap x64 instretW", 64'(if64.instretW), 0);
        checkOutput("wrap x32 instretW", 64'(if32.instretW), 16);

        // Randomised stream against the model
        for (int i = 0; i < 400; i++) begin
            d = genInstr();
            applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
